instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
- Small synchronous FIFO between instruction fetch and instruction decode.
- Decouples fetch from decode back-pressure. Each entry holds an instruction word and its fetch PC.
- Valid/ready handshake on both sides.
- Single-cycle flush discards all buffered entries on a control-flow redirect (branch/jump resolved downstream).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- DATA_W, 32, instruction word width
- ADDR_W, 32, PC width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous discard of all entries
- in_valid  input  1  fetch presents a word
- in_ready  output  1  queue can accept a word this cycle
- in_pc  input  ADDR_W  PC of the presented word
- in_instr  input  DATA_W  presented instruction word
- out_valid  output  1  head entry valid
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  ADDR_W  PC of head entry
- out_instr  output  DATA_W  head instruction word
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, asynchronous):
  - rd_ptr, wr_ptr and count all 0.
  - out_valid=0, in_ready=1 after reset releases.
  - Storage contents need not be reset.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - No transfer when the respective valid/ready is low.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready. A full queue does not accept a push even when a pop occurs in the same cycle.
- out_valid = (count != 0). out_pc/out_instr come from the storage entry at rd_ptr. When empty they are forced to 0.
- Latency:
  - A word pushed in cycle N is visible at the output in cycle N+1 at the earliest.
  - No same-cycle bypass.
  - Throughput is 1 word/cycle with simultaneous push and pop.
- Pointers:
  - Width $clog2(DEPTH), wrap naturally modulo DEPTH.
  - wr_ptr increments on push; rd_ptr increments on pop.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- Flush (highest priority):
  - flush=1 in cycle N sets count=0 and rd_ptr=wr_ptr=0 at edge N+1.
  - A push or pop in cycle N is ignored; the pushed word is dropped and decode's pop is void.
  - out_valid=0 in cycle N+1. in_ready stays as computed in cycle N.
- Boundary cases:
  - Empty + out_ready: no state change.
  - Full + in_valid: word is not accepted; fetch must hold it.
  - Pop-to-empty and push in the same cycle: count stays 1; the new word becomes head.
  - Reset asserted mid-operation: state clears immediately regardless of clk; buffered entries are lost.
- Order: strict FIFO. The PC/instr pairing is never split.

Decomposition:
- Shared package `cpu_pkg`:
  - PC_W=32, INSTR_W=32.
  - TEXT_BASE=32'h0040_0000, the fetch start address used by the bench.
  - NOP encoding 32'h0000_0000.
- One sub-module, `prefetch_queue_storage`:
  - DEPTH x (ADDR_W+DATA_W) register array.
  - Synchronous write port (we, waddr, wdata) and combinational read port (raddr, rdata).
  - No reset on the array.
- Pointer, count and flush control live in the top module.

Test Plan:
- Reset then idle: rst low, release, 5 cycles with in_valid=0 -> out_valid=0, in_ready=1, count=0, out_instr=0.
- Fill without drain: push PCs 0x00400000..0x0040000C (instrs 0x20080001..0x20080004), out_ready=0 -> count=4, in_ready=0, fifth push (PC 0x00400010) held, not stored; head out_pc=0x00400000.
- Streaming: in_valid=1 and out_ready=1 every cycle for 10 words -> count stays 1 after the first cycle, output sequence equals input sequence, one-cycle latency.
- Full + simultaneous pop: queue full, out_ready=1, in_valid=1 -> head pops, push rejected that cycle, count=3; push accepted the next cycle, count=4.
- Flush with push: 3 entries, flush=1 with in_valid=1 (PC 0x00400020) -> next cycle count=0, out_valid=0; the following push of PC 0x00400040 appears as head.
- Async reset mid-stream: rst driven low between clock edges with 2 entries -> out_valid drops immediately, count=0 before the next clk edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU front-end widths and constants
package cpu_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: fetch-side and decode-side valid/ready bundle
interface instr_prefetch_queue_if import cpu_pkg::*; #(
  parameter int ADDR_W = PC_W,
  parameter int DATA_W = INSTR_W
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [ADDR_W-1:0] in_pc, out_pc;
  logic [DATA_W-1:0] in_instr, out_instr;
  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input in_ready, out_valid, out_pc, out_instr
  );
  modport slave (
    input in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/prefetch_queue_storage.sv
// prefetch_queue_storage: unreset register array, sync write, comb read
module prefetch_queue_storage #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetch-to-decode FIFO of {pc, instr} with single-cycle flush
module instr_prefetch_queue import cpu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int DATA_W = INSTR_W,
  parameter int ADDR_W = PC_W,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  instr_prefetch_queue_if.slave  q,
  output logic [PW:0]            count
);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0] count_q, count_d;
  logic push, pop;
  logic [ADDR_W+DATA_W-1:0] rdata;
  assign q.in_ready = count_q != FULL;
  assign q.out_valid = count_q != '0;
  assign q.out_pc = q.out_valid ? rdata[ADDR_W+DATA_W-1:DATA_W] : '0;
  assign q.out_instr = q.out_valid ? rdata[DATA_W-1:0] : DATA_W'(NOP);
  assign count = count_q;
  always_comb begin
    push = q.in_valid & q.in_ready;
    pop = q.out_valid & q.out_ready;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  prefetch_queue_storage #(.DEPTH(DEPTH), .W(ADDR_W+DATA_W)) u_storage (
    .clk(clk),
    .we(push & ~flush),
    .waddr(wr_ptr_q),
    .wdata({q.in_pc, q.in_instr}),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed + random stimulus against a queue-based model
module tb_instr_prefetch_queue;
  import cpu_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0, flush = 0;
  logic [2:0] count;
  logic [63:0] mq [$];
  int checks = 0, failures = 0;
  instr_prefetch_queue_if #(.ADDR_W(PC_W), .DATA_W(INSTR_W)) q ();
  instr_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .q(q.slave),
    .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(bit v, logic [31:0] pc, logic [31:0] ins, bit rdy, bit fl);
    q.in_valid = v;
    q.in_pc = pc;
    q.in_instr = ins;
    q.out_ready = rdy;
    flush = fl;
  endtask
  task automatic cycle();
    bit m_push, m_pop;
    logic [63:0] head;
    @(negedge clk);
    head = mq.size() != 0 ? mq[0] : 64'd0;
    chk("in_ready", 64'(q.in_ready), 64'(mq.size() != DEPTH));
    chk("out_valid", 64'(q.out_valid), 64'(mq.size() != 0));
    chk("out_pc", 64'(q.out_pc), 64'(head[63:32]));
    chk("out_instr", 64'(q.out_instr), 64'(head[31:0]));
    chk("count", 64'(count), 64'(mq.size()));
    m_push = q.in_valid && mq.size() < DEPTH;
    m_pop = q.out_ready && mq.size() > 0;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({q.in_pc, q.in_instr});
    end
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (5) cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, TEXT_BASE + 32'(4*i), 32'h2008_0001 + 32'(i), 0, 0);
      cycle();
    end
    drive(1, TEXT_BASE + 32'h10, 32'h2008_0005, 0, 0);
    repeat (2) cycle();
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_head", 64'(q.out_pc), 64'(TEXT_BASE));
    drive(1, TEXT_BASE + 32'h10, 32'h2008_0005, 1, 0);
    cycle();
    chk("full_pop_count", 64'(count), 64'd3);
    drive(1, TEXT_BASE + 32'h10, 32'h2008_0005, 0, 0);
    cycle();
    chk("full_push_count", 64'(count), 64'd4);
    drive(0, 0, 0, 1, 0);
    repeat (5) cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1, TEXT_BASE + 32'h100 + 32'(4*i), $urandom, 1, 0);
      cycle();
      chk("stream_count", 64'(count), 64'd1);
    end
    drive(0, 0, 0, 1, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, TEXT_BASE + 32'h200 + 32'(4*i), $urandom, 0, 0);
      cycle();
    end
    drive(1, TEXT_BASE + 32'h20, 32'h1111_1111, 0, 1);
    cycle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(q.out_valid), 64'd0);
    drive(1, TEXT_BASE + 32'h40, 32'h2222_2222, 0, 0);
    cycle();
    chk("flush_head", 64'(q.out_pc), 64'(TEXT_BASE + 32'h40));
    drive(1, TEXT_BASE + 32'h44, 32'h3333_3333, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle();
    #2 rst = 0;
    #1;
    chk("arst_valid", 64'(q.out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    mq.delete();
    @(posedge clk);
    #1 rst = 1;
    repeat (2) cycle();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
